// File: rtl/vga_timing_gen_if.sv
// VGA timing generator bus: pixel position, timing strobes and colour path.
// The generator side (master) drives the timing and colour to the DAC; the
// pixel source side (slave) reads the position and supplies rgb_in.
interface vga_timing_gen_if;
  logic [2:0] rgb_in;
  logic [9:0] pix_x;
  logic [9:0] pix_y;
  logic       p_tick;
  logic       video_on;
  logic       hsync;
  logic       vsync;
  logic [2:0] rgb;
  logic       frame_start;

  modport master (
    input  rgb_in,
    output pix_x, pix_y, p_tick, video_on, hsync, vsync, rgb, frame_start
  );

  modport slave (
    output rgb_in,
    input  pix_x, pix_y, p_tick, video_on, hsync, vsync, rgb, frame_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA timing generator: pixel-clock divider, horizontal/vertical counters,
// registered sync pulses and blanked colour output. Everything runs in the
// single clk domain; p_tick is a clock enable, never a clock.
module vga_timing_gen #(
  parameter int CLK_DIV  = 2,
  parameter int H_DISP   = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_DISP   = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SYNC_POL = 0
) (
  input  logic          clk,
  input  logic          reset,
  vga_timing_gen_if.master vga
);

  localparam int H_TOT = H_DISP + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_DISP + V_FP + V_SYNC + V_BP;

  localparam logic [3:0] DIV_LAST     = 4'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST       = 10'(H_TOT - 1);
  localparam logic [9:0] V_LAST       = 10'(V_TOT - 1);
  localparam logic [9:0] H_DISP_W     = 10'(H_DISP);
  localparam logic [9:0] V_DISP_W     = 10'(V_DISP);
  localparam logic [9:0] H_SYNC_FIRST = 10'(H_DISP + H_FP);
  localparam logic [9:0] H_SYNC_LAST  = 10'(H_DISP + H_FP + H_SYNC - 1);
  localparam logic [9:0] V_SYNC_FIRST = 10'(V_DISP + V_FP);
  localparam logic [9:0] V_SYNC_LAST  = 10'(V_DISP + V_FP + V_SYNC - 1);

  // Active and idle sync levels; idle is what reset drives.
  localparam logic SYNC_ACT  = (SYNC_POL != 0);
  localparam logic SYNC_IDLE = (SYNC_POL == 0);

  logic [3:0] div_q, div_d;
  logic       p_tick_q, p_tick_d;
  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic [2:0] rgb_q, rgb_d;
  logic       frame_start_q, frame_start_d;

  logic       div_last;
  logic       x_last;
  logic       y_last;
  logic       video_on;
  logic       h_sync_zone;
  logic       v_sync_zone;

  // Pixel divider: p_tick goes high for the one clk that closes each pixel.
  // With CLK_DIV = 1 div_q stays 0, so p_tick is high every clk.
  always_comb begin
    div_last = (div_q == DIV_LAST);
    div_d    = div_last ? 4'd0 : div_q + 4'd1;
    p_tick_d = div_last;
  end

  // Raster counters: x advances at the end of a p_tick clk, y on x wrap.
  always_comb begin
    x_last = (x_q == H_LAST);
    y_last = (y_q == V_LAST);
    x_d    = x_q;
    y_d    = y_q;
    if (p_tick_q) begin
      if (x_last) begin
        x_d = 10'd0;
        y_d = y_last ? 10'd0 : y_q + 10'd1;
      end else begin
        x_d = x_q + 10'd1;
      end
    end
  end

  // Region decode from the live counters.
  always_comb begin
    video_on    = (x_q < H_DISP_W) && (y_q < V_DISP_W);
    h_sync_zone = (x_q >= H_SYNC_FIRST) && (x_q <= H_SYNC_LAST);
    v_sync_zone = (y_q >= V_SYNC_FIRST) && (y_q <= V_SYNC_LAST);
  end

  // Output stage: syncs and colour capture the pixel that p_tick closes,
  // so they trail the counters by one pixel; frame_start marks the wrap.
  always_comb begin
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    rgb_d         = rgb_q;
    frame_start_d = p_tick_q && x_last && y_last;
    if (p_tick_q) begin
      hsync_d = h_sync_zone ? SYNC_ACT : SYNC_IDLE;
      vsync_d = v_sync_zone ? SYNC_ACT : SYNC_IDLE;
      rgb_d   = video_on ? vga.rgb_in : 3'b000;
    end
  end

  // State register with synchronous reset; reset restarts the raster at (0,0).
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q         <= 4'd0;
      p_tick_q      <= 1'b0;
      x_q           <= 10'd0;
      y_q           <= 10'd0;
      hsync_q       <= SYNC_IDLE;
      vsync_q       <= SYNC_IDLE;
      rgb_q         <= 3'b000;
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      p_tick_q      <= p_tick_d;
      x_q           <= x_d;
      y_q           <= y_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      rgb_q         <= rgb_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign vga.pix_x       = x_q;
  assign vga.pix_y       = y_q;
  assign vga.p_tick      = p_tick_q;
  assign vga.video_on    = video_on;
  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;
  assign vga.rgb         = rgb_q;
  assign vga.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen. dut_a uses a tiny raster (15 x 8 pixels,
// CLK_DIV = 2, active-low syncs) so whole frames fit in a short run;
// dut_b uses the default 800-pixel line with CLK_DIV = 1, active-high syncs.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic reset_a = 1'b1;
  logic reset_b = 1'b1;

  always #5 clk = ~clk;

  vga_timing_gen_if if_a ();
  vga_timing_gen_if if_b ();

  vga_timing_gen #(
    .CLK_DIV(2), .H_DISP(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_DISP(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(0)
  ) dut_a (
    .clk(clk), .reset(reset_a), .vga(if_a)
  );

  vga_timing_gen #(
    .CLK_DIV(1), .SYNC_POL(1)
  ) dut_b (
    .clk(clk), .reset(reset_b), .vga(if_b)
  );

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int         steps;   // pixel advances before the check
    logic [2:0] rgb_in;
    logic [9:0] x;
    logic [9:0] y;
    logic       von;
    logic       hs;
    logic       vs;
    logic [2:0] rgb;
    logic       fs;
  } vec_t;

  vec_t vecs [15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Advance dut_a by one pixel: wait for p_tick, then let the edge that
  // ends the p_tick clk update the counters; returns at the next negedge.
  task automatic advance_a();
    int n = 0;
    while (if_a.p_tick !== 1'b1 && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (if_a.p_tick !== 1'b1) begin
      n_cmp++;
      n_err++;
      $display("FAIL p_tick_timeout: got no p_tick within %0d clks, expected one within 2", n);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic advance_n(input int n);
    for (int k = 0; k < n; k++) advance_a();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000 ns, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int clks;
    int ticks;
    int line_ticks;
    int hs_low;
    int no_tick;
    int hs_high;
    int vs_high;
    logic [9:0] first_hs_x;
    bit seen_hs;

    // Hand-computed raster for dut_a: H_TOT=15 (hsync x 10..12), V_TOT=8
    // (vsync y 5..6), visible 8x4. Registered outputs show the previous pixel.
    vecs[0]  = '{1,  3'b101, 10'd1,  10'd0, 1'b1, 1'b1, 1'b1, 3'b101, 1'b0};
    vecs[1]  = '{8,  3'b111, 10'd9,  10'd0, 1'b0, 1'b1, 1'b1, 3'b000, 1'b0};
    vecs[2]  = '{2,  3'b111, 10'd11, 10'd0, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0};
    vecs[3]  = '{2,  3'b111, 10'd13, 10'd0, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0};
    vecs[4]  = '{1,  3'b111, 10'd14, 10'd0, 1'b0, 1'b1, 1'b1, 3'b000, 1'b0};
    vecs[5]  = '{1,  3'b111, 10'd0,  10'd1, 1'b1, 1'b1, 1'b1, 3'b000, 1'b0};
    vecs[6]  = '{1,  3'b111, 10'd1,  10'd1, 1'b1, 1'b1, 1'b1, 3'b111, 1'b0};
    vecs[7]  = '{44, 3'b111, 10'd0,  10'd4, 1'b0, 1'b1, 1'b1, 3'b000, 1'b0};
    vecs[8]  = '{15, 3'b111, 10'd0,  10'd5, 1'b0, 1'b1, 1'b1, 3'b000, 1'b0};
    vecs[9]  = '{1,  3'b111, 10'd1,  10'd5, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0};
    vecs[10] = '{29, 3'b111, 10'd0,  10'd7, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0};
    vecs[11] = '{1,  3'b111, 10'd1,  10'd7, 1'b0, 1'b1, 1'b1, 3'b000, 1'b0};
    vecs[12] = '{13, 3'b111, 10'd14, 10'd7, 1'b0, 1'b1, 1'b1, 3'b000, 1'b0};
    vecs[13] = '{1,  3'b010, 10'd0,  10'd0, 1'b1, 1'b1, 1'b1, 3'b000, 1'b1};
    vecs[14] = '{1,  3'b010, 10'd1,  10'd0, 1'b1, 1'b1, 1'b1, 3'b010, 1'b0};

    if_a.rgb_in = 3'b000;
    if_b.rgb_in = 3'b000;

    // Reset state of both instances.
    repeat (3) @(negedge clk);
    check("rst_a.x", 32'(if_a.pix_x), 0);
    check("rst_a.y", 32'(if_a.pix_y), 0);
    check("rst_a.p_tick", 32'(if_a.p_tick), 0);
    check("rst_a.fs", 32'(if_a.frame_start), 0);
    check("rst_a.hs", 32'(if_a.hsync), 1);
    check("rst_a.vs", 32'(if_a.vsync), 1);
    check("rst_a.rgb", 32'(if_a.rgb), 0);
    check("rst_b.hs", 32'(if_b.hsync), 0);
    check("rst_b.vs", 32'(if_b.vsync), 0);
    check("rst_b.p_tick", 32'(if_b.p_tick), 0);
    $display("reset: a x=%0d y=%0d hs=%0b vs=%0b  b hs=%0b vs=%0b",
             if_a.pix_x, if_a.pix_y, if_a.hsync, if_a.vsync, if_b.hsync, if_b.vsync);
    reset_a = 1'b0;

    // Table-driven raster walk over one full frame and the wrap.
    for (int i = 0; i < 15; i++) begin
      if_a.rgb_in = vecs[i].rgb_in;
      advance_n(vecs[i].steps);
      check($sformatf("vec%0d.x", i),   32'(if_a.pix_x),       32'(vecs[i].x));
      check($sformatf("vec%0d.y", i),   32'(if_a.pix_y),       32'(vecs[i].y));
      check($sformatf("vec%0d.von", i), 32'(if_a.video_on),    32'(vecs[i].von));
      check($sformatf("vec%0d.hs", i),  32'(if_a.hsync),       32'(vecs[i].hs));
      check($sformatf("vec%0d.vs", i),  32'(if_a.vsync),       32'(vecs[i].vs));
      check($sformatf("vec%0d.rgb", i), 32'(if_a.rgb),         32'(vecs[i].rgb));
      check($sformatf("vec%0d.fs", i),  32'(if_a.frame_start), 32'(vecs[i].fs));
      $display("vec %0d: x=%0d y=%0d von=%0b hs=%0b vs=%0b rgb=%03b fs=%0b",
               i, if_a.pix_x, if_a.pix_y, if_a.video_on, if_a.hsync, if_a.vsync,
               if_a.rgb, if_a.frame_start);
    end

    // Frame period: 15*8*2 = 240 clks and 120 p_ticks between frame_starts,
    // 15 p_ticks on line 0.
    clks = 0;
    while (if_a.frame_start !== 1'b1 && clks < 400) begin
      @(negedge clk);
      clks++;
    end
    check("fs_first_seen", 32'(if_a.frame_start), 1);
    clks = 0; ticks = 0; line_ticks = 0;
    do begin
      @(negedge clk);
      clks++;
      if (if_a.p_tick === 1'b1) begin
        ticks++;
        if (if_a.pix_y == 10'd0) line_ticks++;
      end
    end while (if_a.frame_start !== 1'b1 && clks < 400);
    check("frame_clks", 32'(clks), 240);
    check("frame_ticks", 32'(ticks), 120);
    check("line_ticks", 32'(line_ticks), 15);
    $display("frame: clks=%0d p_ticks=%0d line_ticks=%0d", clks, ticks, line_ticks);

    // Mid-frame reset at a visible pixel (5,2) with colour on the output.
    if_a.rgb_in = 3'b111;
    advance_n(35);
    check("mid.x_pre", 32'(if_a.pix_x), 5);
    check("mid.y_pre", 32'(if_a.pix_y), 2);
    check("mid.rgb_pre", 32'(if_a.rgb), 7);
    reset_a = 1'b1;
    @(negedge clk);
    check("mid.x", 32'(if_a.pix_x), 0);
    check("mid.y", 32'(if_a.pix_y), 0);
    check("mid.hs", 32'(if_a.hsync), 1);
    check("mid.vs", 32'(if_a.vsync), 1);
    check("mid.rgb", 32'(if_a.rgb), 0);
    check("mid.p_tick", 32'(if_a.p_tick), 0);
    $display("mid-frame reset: x=%0d y=%0d hs=%0b vs=%0b rgb=%03b",
             if_a.pix_x, if_a.pix_y, if_a.hsync, if_a.vsync, if_a.rgb);
    reset_a = 1'b0;

    // First p_tick CLK_DIV clks after release; the frame then runs a full
    // 120 p_ticks (the first included) to frame_start, and line 0 carries
    // one complete 3-pixel (6-clk) hsync pulse.
    clks = 0;
    do begin
      @(negedge clk);
      clks++;
    end while (if_a.p_tick !== 1'b1 && clks < 20);
    check("rel.first_tick_clks", 32'(clks), 2);
    ticks = 1; hs_low = 0; clks = 0;
    do begin
      @(negedge clk);
      clks++;
      if (if_a.p_tick === 1'b1) ticks++;
      if (if_a.pix_y == 10'd0 && if_a.hsync === 1'b0) hs_low++;
    end while (if_a.frame_start !== 1'b1 && clks < 400);
    check("rel.ticks_to_fs", 32'(ticks), 120);
    check("rel.fs", 32'(if_a.frame_start), 1);
    check("rel.hs_line0_clks", 32'(hs_low), 6);
    $display("after reset: p_ticks to frame_start=%0d line0 hsync clks=%0d", ticks, hs_low);

    // dut_b: CLK_DIV=1, active-high sync, 800-clk lines.
    @(negedge clk);
    reset_b = 1'b0;
    no_tick = 0; hs_high = 0; vs_high = 0; seen_hs = 1'b0; first_hs_x = '0;
    for (int n = 0; n < 800; n++) begin
      @(negedge clk);
      if (if_b.p_tick !== 1'b1) no_tick++;
      if (if_b.vsync === 1'b1) vs_high++;
      if (if_b.hsync === 1'b1) begin
        hs_high++;
        if (!seen_hs) begin
          seen_hs = 1'b1;
          first_hs_x = if_b.pix_x;
        end
      end
    end
    check("b.p_tick_low_clks", 32'(no_tick), 0);
    check("b.hs_high_clks", 32'(hs_high), 96);
    check("b.hs_first_x", 32'(first_hs_x), 657);
    check("b.vs_high_clks", 32'(vs_high), 0);
    $display("dut_b line: p_tick low=%0d hsync high=%0d first x=%0d", no_tick, hs_high, first_hs_x);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2; system clocks per pixel (legal values 1..16).
REQ-002 SHALL have parameter H_DISP, default 640; visible pixels per line.
REQ-003 SHALL have parameter H_FP / H_SYNC / H_BP, defaults 16 / 96 / 48; horizontal front porch, sync and back porch in pixels.
REQ-004 SHALL have parameter V_DISP, default 480; visible lines per frame.
REQ-005 SHALL have parameter V_FP / V_SYNC / V_BP, defaults 10 / 2 / 33; vertical front porch, sync and back porch in lines.
REQ-006 SHALL have parameter SYNC_POL, default 0; 0 = sync pulses active-low, 1 = active-high.
REQ-007 clk  input  1  system clock; the single clock domain.
REQ-008 reset  input  1  reset; synchronous to clk, active-high.
REQ-009 rgb_in  input  3  pixel colour from the text/graphics generator for the current pix_x, pix_y.
REQ-010 pix_x  output  10  current horizontal pixel count.
REQ-011 pix_y  output  10  current vertical line count.
REQ-012 p_tick  output  1  one-clk pulse marking each pixel period.
REQ-013 video_on  output  1  high when pix_x < H_DISP and pix_y < V_DISP.
REQ-014 hsync, vsync  output  1 each  registered sync pulses, polarity per SYNC_POL.
REQ-015 rgb  output  3  registered colour to the DAC; 0 when blanked.
REQ-016 frame_start  output  1  one-clk pulse when the counters wrap to (0,0).

Function
REQ-017 SHALL generate p_tick with a mod-CLK_DIV divider counter: high for exactly one clk every CLK_DIV clks; constant 1 when CLK_DIV = 1.
REQ-018 Horizontal count SHALL advance only on p_tick, wrapping H_TOT-1 -> 0, where H_TOT = H_DISP+H_FP+H_SYNC+H_BP (800 by default).
REQ-019 Vertical count SHALL advance only on p_tick coinciding with horizontal wrap; it wraps V_TOT-1 -> 0, where V_TOT = V_DISP+V_FP+V_SYNC+V_BP (525 by default).
REQ-020 pix_x and pix_y SHALL be the counter registers directly; both hold steady between p_ticks.
REQ-021 video_on SHALL be combinational from the counters.
REQ-022 Horizontal sync SHALL be asserted for H_DISP+H_FP <= x <= H_DISP+H_FP+H_SYNC-1 (656..751 by default).
REQ-023 Vertical sync SHALL be asserted for V_DISP+V_FP <= y <= V_DISP+V_FP+V_SYNC-1 (490..491 by default).
REQ-024 hsync, vsync and rgb SHALL be registered on p_tick, giving one pixel period of latency from the counters.
REQ-025 rgb SHALL register rgb_in when video_on is 1, and 3'b000 otherwise.
REQ-026 frame_start SHALL pulse for one clk on the p_tick at which both counters wrap to 0.
REQ-027 Counter widths SHALL be 10 bits; values SHALL never reach H_TOT or V_TOT.
REQ-028 Outputs SHALL be glitch-free; no output SHALL change except on the clk edge.

Reset
REQ-029 While reset = 1 at a clk edge, the divider, pix_x, pix_y and rgb SHALL become 0, p_tick and frame_start SHALL be 0, and hsync/vsync SHALL be at the inactive level (1 if SYNC_POL = 0).
REQ-030 Reset asserted mid-line or mid-frame SHALL abort immediately.
REQ-031 After reset deasserts, the first p_tick SHALL occur CLK_DIV clks later, and counting SHALL restart from (0,0) with no partial sync pulse.

Verification
REQ-032 Defaults, full frame: count clks between frame_start pulses = 800*525*2 = 840000; count p_ticks per line = 800.
REQ-033 Sync timing: hsync low for exactly 96 p_ticks beginning at registered x = 657 (one pixel of latency); vsync low for exactly 2 lines beginning at line 490 (+1 pixel of latency).
REQ-034 Blanking: rgb_in held at 3'b111 -> rgb = 3'b111 only for 640x480 pixels per frame, and 3'b000 at x = 640..799 and y = 480..524.
REQ-035 Wrap: x = 799, y = 524 on p_tick -> next state is x = 0, y = 0, with frame_start = 1 for one clk.
REQ-036 Reset mid-frame at x = 300, y = 200 -> next clk: pix_x = 0, pix_y = 0, hsync = vsync = 1, rgb = 0; the next frame_start follows 840000 clks after the first p_tick.
REQ-037 CLK_DIV = 1, SYNC_POL = 1: p_tick constantly 1; hsync is high for 96 clks per 800-clk line.
